// File: rtl/multichannel_pattern_csr_if.sv
// Avalon-MM slave bus bundle used by the pattern CSR block.
interface avalon_mm_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    read;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport master (
    output address, write, writedata, byteenable, read,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, write, writedata, byteenable, read,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/multichannel_pattern_csr.sv
// Per-channel key/length/enable CSRs with shadow keys committed atomically
// at a datapath idle point; writes to a channel with a pending commit are stalled.
module multichannel_pattern_csr #(
  parameter int REG_WIDTH  = 32,
  parameter int SYM_WIDTH  = 8,
  parameter int PAT_SYMS   = 12,
  parameter int CHANNELS   = 2,
  parameter int KEY_WORDS  = (PAT_SYMS * SYM_WIDTH + REG_WIDTH - 1) / REG_WIDTH,
  parameter int ADDR_WIDTH = $clog2(CHANNELS * 8)
) (
  input  logic                                 clk_i,
  input  logic                                 arst_i,
  avalon_mm_if.slave                           amm_slave_if,
  input  logic [CHANNELS-1:0]                  idle_i,
  output logic [CHANNELS*PAT_SYMS*SYM_WIDTH-1:0] pattern_o,
  output logic [CHANNELS*8-1:0]                pat_len_o,
  output logic [CHANNELS-1:0]                  enable_o
);

  localparam int PAT_BITS = PAT_SYMS * SYM_WIDTH;
  localparam int KEY_BITS = KEY_WORDS * REG_WIDTH;
  localparam int BE_WIDTH = REG_WIDTH / 8;
  localparam logic [7:0] LEN_MAX  = 8'(PAT_SYMS);
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_KEY0   = 3'd2;
  localparam logic [3:0] KEY_END    = 4'(2 + KEY_WORDS);
  // Symbols at or above PAT_SYMS in the last key word are forced to zero.
  localparam logic [KEY_BITS-1:0] KEY_MASK = {KEY_BITS{1'b1}} >> (KEY_BITS - PAT_BITS);

  function automatic logic [REG_WIDTH-1:0] be_merge(
    input logic [REG_WIDTH-1:0] old_v,
    input logic [REG_WIDTH-1:0] new_v,
    input logic [BE_WIDTH-1:0]  be_v
  );
    logic [REG_WIDTH-1:0] res_v;
    for (int b = 0; b < BE_WIDTH; b++) begin
      res_v[b*8 +: 8] = be_v[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res_v;
  endfunction

  logic [KEY_BITS-1:0]  key_sh_r  [CHANNELS];
  logic [KEY_BITS-1:0]  key_act_r [CHANNELS];
  logic [7:0]           len_sh_r  [CHANNELS];
  logic [7:0]           len_act_r [CHANNELS];
  logic [CHANNELS-1:0]  enable_r;
  logic [CHANNELS-1:0]  pending_r;
  logic [CHANNELS-1:0]  len_err_r;
  logic [REG_WIDTH-1:0] readdata_r;
  logic                 readdatavalid_r;

  logic [ADDR_WIDTH-1:0] ch_addr_s;
  logic [2:0]            off_s;
  logic [2:0]            kidx_s;
  logic                  key_hit_s;
  logic [CHANNELS-1:0]   sel_s;
  logic                  waitrequest_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  action_s;
  logic [REG_WIDTH-1:0]  ctrl_cur_s [CHANNELS];
  logic [REG_WIDTH-1:0]  ctrl_new_s [CHANNELS];
  logic [REG_WIDTH-1:0]  status_s   [CHANNELS];
  logic [REG_WIDTH-1:0]  key_old_s  [CHANNELS];
  logic [REG_WIDTH-1:0]  key_new_s  [CHANNELS];
  logic [REG_WIDTH-1:0]  rd_word_s  [CHANNELS];
  logic [CHANNELS-1:0]   len_ok_s;
  logic [REG_WIDTH-1:0]  rd_data_s;

  assign ch_addr_s = amm_slave_if.address >> 3'd3;
  assign off_s     = amm_slave_if.address[2:0];
  assign kidx_s    = off_s - OFF_KEY0;
  assign key_hit_s = (off_s >= OFF_KEY0) && ({1'b0, off_s} < KEY_END);
  assign action_s  = amm_slave_if.byteenable[0] & amm_slave_if.writedata[1];

  // Address decode and the pending-commit write stall.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      sel_s[c] = (ch_addr_s == ADDR_WIDTH'(c));
    end
    waitrequest_s = amm_slave_if.write && ((off_s == OFF_CTRL) || key_hit_s) &&
                    (|(sel_s & pending_r));
    wr_acc_s = amm_slave_if.write & ~waitrequest_s;
    rd_acc_s = amm_slave_if.read & ~amm_slave_if.write;
  end

  // Per-channel current/merged register images and readback words.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      ctrl_cur_s[c]       = '0;
      ctrl_cur_s[c][0]    = enable_r[c];
      ctrl_cur_s[c][15:8] = len_sh_r[c];
      ctrl_new_s[c] = be_merge(ctrl_cur_s[c], amm_slave_if.writedata, amm_slave_if.byteenable);
      len_ok_s[c]   = (ctrl_new_s[c][15:8] != 8'd0) && (ctrl_new_s[c][15:8] <= LEN_MAX);
      status_s[c]    = '0;
      status_s[c][0] = pending_r[c];
      status_s[c][1] = len_err_r[c];
      key_old_s[c]   = '0;
      for (int w = 0; w < KEY_WORDS; w++) begin
        key_old_s[c] = (kidx_s == 3'(w)) ? key_sh_r[c][w*REG_WIDTH +: REG_WIDTH] : key_old_s[c];
      end
      key_new_s[c] = be_merge(key_old_s[c], amm_slave_if.writedata, amm_slave_if.byteenable);
      rd_word_s[c] = (off_s == OFF_CTRL)   ? ctrl_cur_s[c] :
                     (off_s == OFF_STATUS) ? status_s[c]   :
                     key_hit_s             ? key_old_s[c]  : '0;
    end
  end

  // Read mux: unselected channels contribute zero, so unmapped reads return 0.
  always_comb begin
    rd_data_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      rd_data_s = rd_data_s | (sel_s[c] ? rd_word_s[c] : '0);
    end
  end

  // Channel register file: shadow writes, commit request and idle-time transfer.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        key_sh_r[c]  <= KEY_MASK;
        key_act_r[c] <= KEY_MASK;
        len_sh_r[c]  <= LEN_MAX;
        len_act_r[c] <= LEN_MAX;
      end
      enable_r  <= '0;
      pending_r <= '0;
      len_err_r <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (pending_r[c] && idle_i[c]) begin
          key_act_r[c] <= key_sh_r[c];
          len_act_r[c] <= len_sh_r[c];
          pending_r[c] <= 1'b0;
        end
        // CTRL and KEY writes are stalled while pending, so no overlap with the transfer.
        if (wr_acc_s && sel_s[c]) begin
          case (off_s)
            OFF_CTRL: begin
              enable_r[c] <= ctrl_new_s[c][0];
              len_sh_r[c] <= ctrl_new_s[c][15:8];
              if (action_s && len_ok_s[c]) begin
                pending_r[c] <= 1'b1;
              end else if (action_s) begin
                len_err_r[c] <= 1'b1;
              end
            end
            OFF_STATUS: begin
              if (action_s) begin
                len_err_r[c] <= 1'b0;
              end
            end
            default: begin
              for (int w = 0; w < KEY_WORDS; w++) begin
                if (key_hit_s && (kidx_s == 3'(w))) begin
                  key_sh_r[c][w*REG_WIDTH +: REG_WIDTH] <=
                    key_new_s[c] & KEY_MASK[w*REG_WIDTH +: REG_WIDTH];
                end
              end
            end
          endcase
        end
      end
    end
  end

  // Fixed one-cycle read response; readdata holds between reads.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      readdata_r      <= '0;
      readdatavalid_r <= 1'b0;
    end else begin
      readdatavalid_r <= rd_acc_s;
      if (rd_acc_s) begin
        readdata_r <= rd_data_s;
      end
    end
  end

  assign amm_slave_if.readdata      = readdata_r;
  assign amm_slave_if.readdatavalid = readdatavalid_r;
  assign amm_slave_if.waitrequest   = waitrequest_s;

  // Flatten active registers onto the datapath outputs.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      pattern_o[c*PAT_BITS +: PAT_BITS] = key_act_r[c][PAT_BITS-1:0];
      pat_len_o[c*8 +: 8]               = len_act_r[c];
    end
    enable_o = enable_r;
  end

endmodule
